// File: rtl/ysyx_24080006_axi_sram_slv.sv
// AXI4 slave backed by a word-addressed internal memory.
// Handles one INCR/FIXED burst at a time and round-robins between the AR and AW channels.
module ysyx_24080006_axi_sram_slv #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0F00_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        awready,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    output logic        wready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        bready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    output logic        arready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid
);
    localparam int unsigned IW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_addr;
    logic [3:0]  r_id;
    logic [7:0]  r_len;
    logic [7:0]  r_beat;
    logic [1:0]  r_size;
    logic        r_fixed;
    logic        r_rd_last;
    logic        r_slverr;
    logic        r_decerr;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_rlast;

    logic        w_gnt_rd, w_gnt_wr;
    logic        w_aw_hs, w_ar_hs, w_w_hs, w_r_hs;
    logic        w_last_beat, w_rd_en;
    logic [31:0] w_nxt_addr, w_rd_addr;

    function automatic logic f_in_win(input logic [31:0] a);
        return (a - BASE_ADDR) < WIN_BYTES;
    endfunction

    function automatic logic [IW-1:0] f_idx(input logic [31:0] a);
        return IW'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [1:0] f_sz(input logic [2:0] s);
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

    // Tie-break favours whichever channel was not served last; r_rd_last=0 after reset gives read first.
    assign w_gnt_rd = arvalid && (!awvalid || !r_rd_last);
    assign w_gnt_wr = awvalid && !w_gnt_rd;
    assign awready  = (r_state == S_IDLE) && !reset && w_gnt_wr;
    assign arready  = (r_state == S_IDLE) && !reset && w_gnt_rd;
    assign wready   = (r_state == S_WDATA);
    assign bvalid   = (r_state == S_WRESP);
    assign rvalid   = (r_state == S_RDATA);
    assign bresp    = !bvalid ? 2'b00 : r_decerr ? 2'b11 : r_slverr ? 2'b10 : 2'b00;
    assign bid      = r_id;
    assign rid      = r_id;
    assign rdata    = r_rdata;
    assign rresp    = r_rresp;
    assign rlast    = rvalid && r_rlast;

    assign w_aw_hs     = awvalid && awready;
    assign w_ar_hs     = arvalid && arready;
    assign w_w_hs      = wvalid && wready;
    assign w_r_hs      = rvalid && rready;
    assign w_last_beat = (r_beat == r_len);
    assign w_nxt_addr  = r_fixed ? r_addr : r_addr + (32'd1 << r_size);
    assign w_rd_en     = w_ar_hs || (w_r_hs && !r_rlast);
    assign w_rd_addr   = (r_state == S_IDLE) ? araddr : w_nxt_addr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_ar_hs) w_next = S_RDATA;
                     else if (w_aw_hs) w_next = S_WDATA;
            S_WDATA: if (w_w_hs && w_last_beat) w_next = S_WRESP;
            S_WRESP: if (bready) w_next = S_IDLE;
            S_RDATA: if (w_r_hs && r_rlast) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_id      <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_size    <= '0;
            r_fixed   <= 1'b0;
            r_rd_last <= 1'b0;
            r_slverr  <= 1'b0;
            r_decerr  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            r_rlast   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ar_hs) begin
                r_rd_last <= 1'b1;
                r_addr    <= araddr;
                r_id      <= arid;
                r_len     <= arlen;
                r_size    <= f_sz(arsize);
                r_fixed   <= (arburst == 2'b00);
                r_beat    <= '0;
                r_rlast   <= (arlen == 8'd0);
            end else if (w_aw_hs) begin
                r_rd_last <= 1'b0;
                r_addr    <= awaddr;
                r_id      <= awid;
                r_len     <= awlen;
                r_size    <= f_sz(awsize);
                r_fixed   <= (awburst == 2'b00);
                r_beat    <= '0;
                r_slverr  <= 1'b0;
                r_decerr  <= 1'b0;
            end
            if (w_w_hs) begin
                if (!f_in_win(r_addr)) r_decerr <= 1'b1;
                if (wlast != w_last_beat) r_slverr <= 1'b1;
                if (!w_last_beat) begin
                    r_beat <= r_beat + 8'd1;
                    r_addr <= w_nxt_addr;
                end
            end
            if (w_r_hs && !r_rlast) begin
                r_beat  <= r_beat + 8'd1;
                r_addr  <= w_nxt_addr;
                r_rlast <= ((r_beat + 8'd1) == r_len);
            end
            if (w_rd_en) begin
                if (f_in_win(w_rd_addr)) begin
                    r_rdata <= r_mem[f_idx(w_rd_addr)];
                    r_rresp <= 2'b00;
                end else begin
                    r_rdata <= '0;
                    r_rresp <= 2'b11;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_w_hs && f_in_win(r_addr)) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb[b]) r_mem[f_idx(r_addr)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_axi_sram_slv.sv
// Directed bench for the AXI SRAM slave: reset values, bursts, strobes, errors, arbitration, mid-burst reset.
module tb_ysyx_24080006_axi_sram_slv;
    logic        clock = 1'b0;
    logic        reset;
    logic        awready, awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready, wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready, bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready, arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_24080006_axi_sram_slv #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0F00_0000)) dut (
        .clock(clock), .reset(reset),
        .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
        .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        bit ok = 1'b0;
        awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awsize = size; awburst = burst;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (awready === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        if (ok) tick();
        awvalid = 1'b0;
        chk("aw_handshake", 32'(ok), 32'd1);
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        bit ok = 1'b0;
        arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (arready === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        if (ok) tick();
        arvalid = 1'b0;
        chk("ar_handshake", 32'(ok), 32'd1);
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last);
        wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
        chk("wready", 32'(wready), 32'd1);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] resp, input logic [3:0] id);
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bresp", 32'(bresp), 32'(resp));
        chk("bid", 32'(bid), 32'(id));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    task automatic do_r(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id,
                        input logic last, input int stall);
        chk("rvalid", 32'(rvalid), 32'd1);
        chk("rdata", rdata, d);
        chk("rresp", 32'(rresp), 32'(resp));
        chk("rid", 32'(rid), 32'(id));
        chk("rlast", 32'(rlast), 32'(last));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("rvalid_hold", 32'(rvalid), 32'd1);
            chk("rdata_hold", rdata, d);
            chk("rlast_hold", 32'(rlast), 32'(last));
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [3:0] id);
        do_aw(a, id, 8'd0, 3'd2, 2'b01);
        do_w(d, s, 1'b1);
        do_b(2'b00, id);
    endtask

    task automatic read_word(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                             input logic [3:0] id);
        do_ar(a, id, 8'd0, 3'd2, 2'b01);
        do_r(d, resp, id, 1'b1, 0);
    endtask

    initial begin
        reset = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        repeat (2) tick();

        // reset values
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ids", 32'({bid, rid, bresp, rresp}), 32'd0);
        reset = 1'b0;
        tick();

        // single write then read
        write_word(32'h0F00_0010, 32'hDEAD_BEEF, 4'hF, 4'h3);
        read_word(32'h0F00_0010, 32'hDEAD_BEEF, 2'b00, 4'h5);

        // INCR len 3, read back with stalls
        do_aw(32'h0F00_0100, 4'h4, 8'd3, 3'd2, 2'b01);
        do_w(32'd1, 4'hF, 1'b0);
        do_w(32'd2, 4'hF, 1'b0);
        do_w(32'd3, 4'hF, 1'b0);
        do_w(32'd4, 4'hF, 1'b1);
        do_b(2'b00, 4'h4);
        do_ar(32'h0F00_0100, 4'h6, 8'd3, 3'd2, 2'b01);
        do_r(32'd1, 2'b00, 4'h6, 1'b0, 0);
        do_r(32'd2, 2'b00, 4'h6, 1'b0, 2);
        do_r(32'd3, 2'b00, 4'h6, 1'b0, 1);
        do_r(32'd4, 2'b00, 4'h6, 1'b1, 3);
        chk("rvalid_after_last", 32'(rvalid), 32'd0);

        // byte strobes
        write_word(32'h0F00_0200, 32'h1122_3344, 4'hF, 4'h1);
        write_word(32'h0F00_0200, 32'hAABB_CCDD, 4'b0101, 4'h1);
        read_word(32'h0F00_0200, 32'h11BB_33DD, 2'b00, 4'h2);

        // FIXED burst hits a single word
        write_word(32'h0F00_0208, 32'h0, 4'hF, 4'h1);
        do_aw(32'h0F00_0204, 4'h8, 8'd2, 3'd2, 2'b00);
        do_w(32'd5, 4'hF, 1'b0);
        do_w(32'd6, 4'hF, 1'b0);
        do_w(32'd7, 4'hF, 1'b1);
        do_b(2'b00, 4'h8);
        read_word(32'h0F00_0204, 32'd7, 2'b00, 4'h2);
        read_word(32'h0F00_0208, 32'd0, 2'b00, 4'h2);

        // size above 2 behaves as 4-byte steps
        do_aw(32'h0F00_0600, 4'h2, 8'd1, 3'd3, 2'b01);
        do_w(32'h0000_AAAA, 4'hF, 1'b0);
        do_w(32'h0000_BBBB, 4'hF, 1'b1);
        do_b(2'b00, 4'h2);
        read_word(32'h0F00_0604, 32'h0000_BBBB, 2'b00, 4'h3);

        // decode errors
        read_word(32'h0000_0000, 32'd0, 2'b11, 4'hC);
        do_aw(32'h0F00_4000, 4'hD, 8'd0, 3'd2, 2'b01);
        do_w(32'h1234_5678, 4'hF, 1'b1);
        do_b(2'b11, 4'hD);
        write_word(32'h0F00_3FFC, 32'h1234_5678, 4'hF, 4'h1);
        do_ar(32'h0F00_3FFC, 4'h1, 8'd1, 3'd2, 2'b01);
        do_r(32'h1234_5678, 2'b00, 4'h1, 1'b0, 0);
        do_r(32'd0, 2'b11, 4'h1, 1'b1, 0);

        // wlast on the wrong beat
        do_aw(32'h0F00_0500, 4'h2, 8'd1, 3'd2, 2'b01);
        do_w(32'h111, 4'hF, 1'b1);
        do_w(32'h222, 4'hF, 1'b0);
        do_b(2'b10, 4'h2);
        do_ar(32'h0F00_0500, 4'h3, 8'd1, 3'd2, 2'b01);
        do_r(32'h111, 2'b00, 4'h3, 1'b0, 0);
        do_r(32'h222, 2'b00, 4'h3, 1'b1, 0);

        // arbitration with both valids held from reset
        reset = 1'b1;
        awvalid = 1'b1; awaddr = 32'h0F00_0300; awid = 4'h9; awlen = 0; awsize = 3'd2; awburst = 2'b01;
        arvalid = 1'b1; araddr = 32'h0F00_0010; arid = 4'h7; arlen = 0; arsize = 3'd2; arburst = 2'b01;
        tick();
        chk("arb_rst_arready", 32'(arready), 32'd0);
        reset = 1'b0;
        #1;
        chk("arb1_arready", 32'(arready), 32'd1);
        chk("arb1_awready", 32'(awready), 32'd0);
        tick();
        chk("arb_busy_arready", 32'(arready), 32'd0);
        chk("arb_busy_awready", 32'(awready), 32'd0);
        do_r(32'hDEAD_BEEF, 2'b00, 4'h7, 1'b1, 0);
        #1;
        chk("arb2_awready", 32'(awready), 32'd1);
        chk("arb2_arready", 32'(arready), 32'd0);
        tick();
        awvalid = 1'b0;
        do_w(32'hCAFE_F00D, 4'hF, 1'b1);
        do_b(2'b00, 4'h9);
        #1;
        chk("arb3_arready", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        do_r(32'hDEAD_BEEF, 2'b00, 4'h7, 1'b1, 0);
        read_word(32'h0F00_0300, 32'hCAFE_F00D, 2'b00, 4'h1);

        // reset during beat 2 of a len-7 write
        do_aw(32'h0F00_0400, 4'h6, 8'd7, 3'd2, 2'b01);
        do_w(32'hA0A0_A0A0, 4'hF, 1'b0);
        do_w(32'hA1A1_A1A1, 4'hF, 1'b0);
        wvalid = 1'b1; wdata = 32'hA2A2_A2A2; wstrb = 4'hF; wlast = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wvalid = 1'b0;
        #1;
        chk("mrst_wready", 32'(wready), 32'd0);
        chk("mrst_bvalid", 32'(bvalid), 32'd0);
        chk("mrst_rvalid", 32'(rvalid), 32'd0);
        chk("mrst_readies", 32'({awready, arready}), 32'd0);
        chk("mrst_ids_resp", 32'({bid, rid, bresp, rresp, rlast}), 32'd0);
        chk("mrst_rdata", rdata, 32'd0);
        do_ar(32'h0F00_0400, 4'hA, 8'd1, 3'd2, 2'b01);
        do_r(32'hA0A0_A0A0, 2'b00, 4'hA, 1'b0, 0);
        do_r(32'hA1A1_A1A1, 2'b00, 4'hA, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_24080006_axi_sram_slv.md
# ysyx_24080006_axi_sram_slv

AXI4 responder (slave) that serves full-width INCR/FIXED bursts from an internal word-addressed memory. It is the counterpart of the core's AXI master port: in simulation builds it terminates the core's memory traffic, and in SoC builds it services the top-level `io_slave_*` channels. It is single-ported: one read or one write burst at a time, with round-robin arbitration between the AR and AW channels.

## Interface
- `DEPTH_WORDS`, 4096: memory size in 32-bit words (power of two).
- `BASE_ADDR`, 32'h0F00_0000: first decoded byte address; window is `DEPTH_WORDS*4` bytes.
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `awready` out 1 / `awvalid` in 1 / `awaddr` in 32 / `awid` in 4 / `awlen` in 8 / `awsize` in 3 / `awburst` in 2: write address channel.
- `wready` out 1 / `wvalid` in 1 / `wdata` in 32 / `wstrb` in 4 / `wlast` in 1: write data channel.
- `bready` in 1 / `bvalid` out 1 / `bresp` out 2 / `bid` out 4: write response channel.
- `arready` out 1 / `arvalid` in 1 / `araddr` in 32 / `arid` in 4 / `arlen` in 8 / `arsize` in 3 / `arburst` in 2: read address channel.
- `rready` in 1 / `rvalid` out 1 / `rresp` out 2 / `rdata` out 32 / `rlast` out 1 / `rid` out 4: read data channel.

## Operation
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE: `awready`/`arready` are asserted combinationally only for the granted channel. When only one valid is present, that channel is granted. When both are valid, the channel not granted last is granted. After reset, read wins the first tie.
- AW handshake: capture addr/id/len/size/burst; clear the beat counter; go to WDATA.
- AR handshake: capture the same fields and issue the beat-0 memory read in the same cycle; go to RDATA.
- Address step per beat:
  - INCR: `+ (1<<size)`.
  - FIXED: no change.
  - WRAP: treated as INCR.
  - Word index = `(addr - BASE_ADDR) >> 2`.
- Sizes above 2 (above 4 bytes) are treated as size 2.
- Decode: an address outside the window (checked per beat) gives response DECERR (2'b11).
  - Reads in error return `rdata = 0`.
  - Writes in error are dropped.
  - Memory is never touched out of range.
- WDATA:
  - `wready = 1`.
  - Each W handshake writes bytes enabled by `wstrb`.
  - A beat counter counts to `awlen`. The burst ends on beat `awlen` regardless of `wlast`.
  - If `wlast` does not match "beat == awlen" on any beat, the final `bresp` is SLVERR (2'b10). The data is still written.
  - After the final beat, go to WRESP.
- WRESP:
  - `bvalid = 1`, `bid` = captured id, `bresp` = OKAY / SLVERR / DECERR. DECERR has priority over SLVERR.
  - On `bready`, return to IDLE.
- RDATA:
  - `rvalid` is held with stable `rdata`/`rresp`/`rlast`/`rid` until `rready`.
  - On each R handshake the next beat's read is issued the same cycle.
  - `rlast = 1` on beat `arlen`. Its handshake returns the FSM to IDLE.
- `rresp` is per beat: OKAY or DECERR.
- Memory contents are not reset and are undefined after power-up.

## Timing
- Reset values: `awready = arready = wready = bvalid = rvalid = rlast = 0`; `bresp = rresp = 0`; `bid = rid = 0`; `rdata = 0`.
- Reset asserted mid-burst: the burst is abandoned and the FSM goes to IDLE on the next edge.
  - Beats already written remain in memory.
  - No response is issued.
  - Arbitration history resets to read priority.
- Read latency: AR handshake at cycle N gives first `rvalid` at N+1.
  - R handshake at cycle M gives the next beat's `rvalid` at M+1, so throughput is 1 beat/cycle with `rready` held high.
  - An `arlen=0` burst occupies cycles N..N+1 minimum.
- Write: AW handshake at N gives `wready` from N+1.
  - Final W handshake at M gives `bvalid` at M+1.
  - Throughput is 1 beat/cycle.
- IDLE re-entry: the earliest next address handshake is the cycle after the B or last-R handshake. Address readies are 0 in all non-IDLE states.
- Simultaneous `awvalid` and `arvalid` in IDLE are resolved as above. The losing valid must be held by the master (AXI rule); the block does not buffer it.
- W beats presented before the AW handshake are not accepted (`wready = 0` in IDLE).

## Test plan
- Single write then read: AW 0x0F00_0010, len 0, `wdata` 0xDEADBEEF, strb 4'hF → `bresp` OKAY, `bid` echoes 4'h3; AR same address → `rdata` 0xDEADBEEF, `rlast = 1`, `rvalid` one cycle after the AR handshake.
- INCR burst len 3 at 0x0F00_0100 writing 1,2,3,4, then a read burst of the same → 4 beats 1..4, `rlast` only on beat 3. With random `rready` stalls, data is held stable.
- Byte strobes: word preset to 0x11223344, write 0xAABBCCDD with strb 4'b0101 → readback 0x11BB33DD. A FIXED burst len 2 writing 5,6,7 → that word reads 7.
- Errors: AR at 0x0000_0000 → `rresp` 2'b11, `rdata = 0`. A write len 1 with `wlast` on beat 0 → 2 beats accepted, `bresp` 2'b10.
- Arbitration: `awvalid` and `arvalid` both held from reset → read granted first, then write, then read. `bid`/`rid` match the originating ids.
- Reset asserted during beat 2 of a len-7 write → all outputs 0 on the next cycle; beats 0–1 persist in memory; a new AR is accepted after `reset` falls.
